// File: rtl/maple_pkg.sv
// rtl/maple_pkg.sv - Maple Bus decoder state encoding and shared framing constants
package maple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END,
    ST_DROP
  } state_t;

  localparam int START_PULSES     = 4;
  localparam int END_PULSES       = 2;
  localparam int DROP_IDLE_CYCLES = 8;

endpackage

// File: rtl/maple_rx_decoder_if.sv
// rtl/maple_rx_decoder_if.sv - byte stream carrying decoded Maple frames
interface maple_rx_decoder_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tstrb;
  logic       tkeep;

  modport master (output tdata, tvalid, tlast, tstrb, tkeep, input tready);
  modport slave  (input tdata, tvalid, tlast, tstrb, tkeep, output tready);

endinterface

// File: rtl/maple_edge_sync.sv
// rtl/maple_edge_sync.sv - line synchronizer (idles high) plus registered edge detector
module maple_edge_sync
  import maple_pkg::*;
#(
  parameter int C_SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [C_SYNC_STAGES-1:0] sync_q;
  logic                     prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[C_SYNC_STAGES-2:0], line};
      prev_q <= sync_q[C_SYNC_STAGES-1];
    end
  end

  assign level = sync_q[C_SYNC_STAGES-1];
  assign fall  = prev_q & ~level;
  assign rise  = ~prev_q & level;

endmodule

// File: rtl/maple_rx_decoder.sv
// rtl/maple_rx_decoder.sv - Maple Bus receive decoder emitting bytes on a stream port
module maple_rx_decoder
  import maple_pkg::*;
#(
  parameter int C_TIMEOUT_CYCLES = 1000,
  parameter int C_SYNC_STAGES    = 2
) (
  input  logic               M_AXIS_ACLK,
  input  logic               M_AXIS_ARESETN,
  input  logic               SDCKA,
  input  logic               SDCKB,
  input  logic               ENABLE,
  maple_rx_decoder_if.master m_axis,
  output logic               RECEIVING,
  output logic               FRAME_ERROR
);

  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

  state_t        state_q, state_d;
  logic          a_lvl, a_fall, a_rise, b_lvl, b_fall, b_rise, any_edge;
  logic [TW-1:0] idle_cnt_q;
  logic [2:0]    pulse_cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [1:0]    a_run_q;
  logic          tent_q;
  logic [5:0]    shreg_q;
  logic [3:0]    hi_cnt_q;
  logic          timeout, proto_err, flush;
  logic          byte_done;
  logic [7:0]    byte_val;
  logic          tvalid_q, tlast_q;
  logic [7:0]    tdata_q;
  logic          pend_valid_q, pend_last_q;
  logic [7:0]    pend_data_q;
  logic          out_free, move, overflow, accept;
  logic          err_q;

  maple_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync_a (
    .clk(M_AXIS_ACLK), .rst_n(M_AXIS_ARESETN), .line(SDCKA),
    .level(a_lvl), .fall(a_fall), .rise(a_rise)
  );

  maple_edge_sync #(.C_SYNC_STAGES(C_SYNC_STAGES)) u_sync_b (
    .clk(M_AXIS_ACLK), .rst_n(M_AXIS_ARESETN), .line(SDCKB),
    .level(b_lvl), .fall(b_fall), .rise(b_rise)
  );

  assign any_edge = a_fall | a_rise | b_fall | b_rise;
  assign timeout  = (state_q != ST_IDLE) && !any_edge &&
                    (idle_cnt_q == TW'(C_TIMEOUT_CYCLES - 1));

  // An SDCKA-sampled bit is only committed once the following SDCKB fall proves it was not the end pattern.
  assign byte_done = (state_q == ST_DATA) && !a_fall && b_fall &&
                     (a_run_q != 2'd0) && (bit_cnt_q == 3'd6);
  assign byte_val  = {shreg_q, tent_q, a_lvl};

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) state_q <= ST_IDLE;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    proto_err = 1'b0;
    flush     = 1'b0;
    if (timeout) begin
      state_d   = ST_IDLE;
      proto_err = 1'b1;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ENABLE && b_lvl && a_fall) state_d = ST_START;
        end
        ST_START: begin
          if (a_rise) begin
            if (pulse_cnt_q == 3'(START_PULSES)) begin
              state_d = ST_DATA;
            end else begin
              state_d   = ST_DROP;
              proto_err = 1'b1;
              flush     = 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (a_fall && (a_run_q == 2'(END_PULSES - 1))) begin
            flush = (bit_cnt_q != 3'd0);
            if (bit_cnt_q == 3'd0) begin
              state_d = ST_END;
            end else begin
              state_d   = ST_DROP;
              proto_err = 1'b1;
            end
          end else if (!a_fall && b_fall && (a_run_q == 2'd0)) begin
            state_d   = ST_DROP;
            proto_err = 1'b1;
            flush     = 1'b1;
          end
        end
        ST_END: begin
          if (a_fall || b_fall) begin
            state_d   = ST_DROP;
            proto_err = 1'b1;
            flush     = 1'b1;
          end else if (b_rise) begin
            state_d = ST_IDLE;
            flush   = 1'b1;
          end
        end
        ST_DROP: begin
          if (a_lvl && b_lvl && (hi_cnt_q == 4'(DROP_IDLE_CYCLES - 1))) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    RECEIVING = (state_q != ST_IDLE);
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      idle_cnt_q  <= '0;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
      a_run_q     <= '0;
      tent_q      <= 1'b0;
      shreg_q     <= '0;
      hi_cnt_q    <= '0;
    end else begin
      if (state_q == ST_IDLE || any_edge) idle_cnt_q <= '0;
      else                                idle_cnt_q <= idle_cnt_q + TW'(1);

      if (state_q != ST_START)                                 pulse_cnt_q <= '0;
      else if (b_fall && !a_lvl && (pulse_cnt_q != 3'd7))      pulse_cnt_q <= pulse_cnt_q + 3'd1;

      if (state_q != ST_DATA) begin
        a_run_q   <= '0;
        bit_cnt_q <= '0;
      end else if (a_fall) begin
        if (a_run_q == 2'(END_PULSES - 1)) begin
          a_run_q <= '0;
        end else begin
          a_run_q <= a_run_q + 2'd1;
          tent_q  <= b_lvl;
        end
      end else if (b_fall && (a_run_q != 2'd0)) begin
        shreg_q   <= {shreg_q[3:0], tent_q, a_lvl};
        bit_cnt_q <= bit_cnt_q + 3'd2;
        a_run_q   <= '0;
      end

      if (state_q == ST_DROP && a_lvl && b_lvl) hi_cnt_q <= hi_cnt_q + 4'd1;
      else                                      hi_cnt_q <= '0;
    end
  end

  // The pending byte is released only when displaced by a newer byte or marked last by frame end/abort.
  assign out_free = !tvalid_q || m_axis.tready;
  assign move     = pend_valid_q && (pend_last_q || byte_done) && out_free;
  assign overflow = byte_done && pend_valid_q && !out_free;
  assign accept   = byte_done && !overflow;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_last_q  <= 1'b0;
      pend_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= proto_err | overflow;

      if (move) begin
        tvalid_q <= 1'b1;
        tdata_q  <= pend_data_q;
        tlast_q  <= pend_last_q;
      end else if (tvalid_q && m_axis.tready) begin
        tvalid_q <= 1'b0;
      end

      if (accept) begin
        pend_valid_q <= 1'b1;
        pend_data_q  <= byte_val;
        pend_last_q  <= 1'b0;
      end else if (move) begin
        pend_valid_q <= 1'b0;
        pend_last_q  <= 1'b0;
      end else if (flush && pend_valid_q) begin
        pend_last_q <= 1'b1;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tstrb  = tvalid_q;
  assign m_axis.tkeep  = tvalid_q;
  assign FRAME_ERROR   = err_q;

endmodule

// File: tb/tb_maple_rx_decoder.sv
// tb/tb_maple_rx_decoder.sv - scoreboard bench driving Maple waveforms into maple_rx_decoder
module tb_maple_rx_decoder;
  import maple_pkg::*;

  localparam int STEP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sda = 1'b1;
  logic sdb = 1'b1;
  logic enable = 1'b1;
  logic receiving, frame_error;

  maple_rx_decoder_if axis();

  maple_rx_decoder #(.C_TIMEOUT_CYCLES(1000), .C_SYNC_STAGES(2)) dut (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .SDCKA(sda), .SDCKB(sdb),
    .ENABLE(enable), .m_axis(axis.master), .RECEIVING(receiving), .FRAME_ERROR(frame_error)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         err_pulses = 0;
  int         ready_mode = 1;
  bit         recv_seen = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] frame_bytes[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    axis.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       axis.tready = 1'b0;
        1:       axis.tready = 1'b1;
        default: axis.tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    logic       stall;
    logic [8:0] held;
    logic [8:0] e;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (frame_error) err_pulses++;
        if (receiving) recv_seen = 1'b1;
        if (stall) begin
          check("hold_valid", 32'(axis.tvalid), 32'd1);
          check("hold_beat", 32'({axis.tlast, axis.tdata}), 32'(held));
        end
        if (axis.tvalid && axis.tready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {axis.tlast, axis.tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat_last_data", 32'({axis.tlast, axis.tdata}), 32'(e));
            check("beat_strb_keep", 32'({axis.tstrb, axis.tkeep}), 32'd3);
          end
        end
        stall = axis.tvalid && !axis.tready;
        held  = {axis.tlast, axis.tdata};
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    repeat (STEP) @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v);
    sda = v;
    step();
  endtask

  task automatic set_b(input logic v);
    sdb = v;
    step();
  endtask

  // Leaves SDCKB low after the last pulse so the first data phase needs no extra SDCKB fall.
  task automatic send_start(input int pulses);
    set_a(1'b0);
    for (int i = 0; i < pulses; i++) begin
      set_b(1'b0);
      if (i != pulses - 1) set_b(1'b1);
    end
    set_a(1'b1);
  endtask

  task automatic bit_a(input logic d);
    set_b(d);
    if (!sda) set_a(1'b1);
    set_a(1'b0);
  endtask

  task automatic bit_b(input logic d);
    set_a(d);
    if (!sdb) set_b(1'b1);
    set_b(1'b0);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) bit_a(v[7-k]);
      else            bit_b(v[7-k]);
    end
  endtask

  task automatic send_end();
    if (!sda) set_a(1'b1);
    set_a(1'b0);
    set_a(1'b1);
    set_a(1'b0);
    set_b(1'b1);
    set_a(1'b1);
  endtask

  task automatic push_frame();
    for (int i = 0; i < frame_bytes.size(); i++)
      exp_q.push_back({(i == frame_bytes.size() - 1), frame_bytes[i]});
  endtask

  task automatic send_frame();
    send_start(START_PULSES);
    foreach (frame_bytes[i]) send_byte(frame_bytes[i]);
    send_end();
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tvalid", 32'(axis.tvalid), 32'd0);
    check("reset_tlast", 32'(axis.tlast), 32'd0);
    check("reset_tdata", 32'(axis.tdata), 32'd0);
    check("reset_strb_keep", 32'({axis.tstrb, axis.tkeep}), 32'd0);
    check("reset_receiving", 32'(receiving), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Four-byte frame with the sink always ready.
    base = err_pulses;
    frame_bytes = '{8'h1C, 8'hA5, 8'h00, 8'hFF};
    push_frame();
    send_frame();
    drain("basic_drain");
    check("basic_no_error", 32'(err_pulses - base), 32'd0);

    // Start pattern with only three SDCKB pulses.
    base = err_pulses;
    send_start(3);
    check("short_start_receiving", 32'(receiving), 32'd1);
    set_b(1'b1);
    repeat (12) @(posedge clk);
    #1;
    check("short_start_recovered", 32'(receiving), 32'd0);
    check("short_start_error", 32'(err_pulses - base), 32'd1);
    drain("short_start_drain");

    // Lines freeze mid-byte: the complete byte must still come out as last.
    base = err_pulses;
    exp_q.push_back({1'b1, 8'h5A});
    send_start(START_PULSES);
    send_byte(8'h5A);
    bit_a(1'b1);
    bit_b(1'b0);
    bit_a(1'b1);
    repeat (1100) @(posedge clk);
    #1;
    check("timeout_receiving", 32'(receiving), 32'd0);
    drain("timeout_drain");
    check("timeout_error", 32'(err_pulses - base), 32'd1);
    set_a(1'b1);
    set_b(1'b1);

    // Sink stalled for a whole three-byte frame: third byte overflows.
    base = err_pulses;
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    frame_bytes = '{8'h11, 8'h22, 8'h33};
    send_frame();
    repeat (10) @(posedge clk);
    #1;
    check("stall_held_valid", 32'(axis.tvalid), 32'd1);
    check("stall_held_data", 32'(axis.tdata), 32'h11);
    check("stall_overflow_error", 32'(err_pulses - base), 32'd1);
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    ready_mode = 1;
    drain("stall_drain");

    // Reset in the middle of a byte, then a clean single-byte frame.
    base = err_pulses;
    send_start(START_PULSES);
    bit_a(1'b1);
    bit_b(1'b0);
    bit_a(1'b1);
    rst_n = 1'b0;
    sda = 1'b1;
    sdb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midreset_tvalid", 32'(axis.tvalid), 32'd0);
    check("midreset_receiving", 32'(receiving), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("postreset_receiving", 32'(receiving), 32'd0);
    frame_bytes = '{8'h42};
    push_frame();
    send_frame();
    drain("postreset_drain");
    check("postreset_no_error", 32'(err_pulses - base), 32'd0);

    // ENABLE low for a whole frame: decoder must stay idle.
    base = err_pulses;
    enable = 1'b0;
    recv_seen = 1'b0;
    frame_bytes = '{8'h3C, 8'hC3};
    send_frame();
    repeat (10) @(posedge clk);
    #1;
    check("disabled_receiving", 32'(recv_seen), 32'd0);
    check("disabled_no_error", 32'(err_pulses - base), 32'd0);
    enable = 1'b1;

    // ENABLE dropped after the start pattern: frame still completes.
    frame_bytes = '{8'h96, 8'h69};
    push_frame();
    send_start(START_PULSES);
    enable = 1'b0;
    foreach (frame_bytes[i]) send_byte(frame_bytes[i]);
    send_end();
    drain("enable_drop_drain");
    enable = 1'b1;

    // Random frames with a randomly stalling sink.
    base = err_pulses;
    ready_mode = 2;
    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(0, 4);
      frame_bytes.delete();
      for (int i = 0; i < len; i++) frame_bytes.push_back(8'($urandom));
      push_frame();
      send_frame();
      repeat ($urandom_range(2, 10)) @(posedge clk);
      #1;
    end
    drain("random_drain");
    check("random_no_error", 32'(err_pulses - base), 32'd0);
    ready_mode = 1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
